// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with a programmable-full flag.
// The head entry is shown on dout whenever the FIFO holds data.
module sync_fwft_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int PROG_FULL = DEPTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic             prog_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_PROG = CW'(PROG_FULL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come only from the registered count.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign prog_full = (count_q >= CNT_PROG);
    assign dout      = mem_q[rd_ptr_q];

    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed checks for sync_fwft_fifo (WIDTH=8, DEPTH=32, PROG_FULL=6).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_sync_fwft_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       full;
    logic       prog_full;
    logic [7:0] dout;
    logic       empty;

    int checks = 0;
    int errors = 0;

    sync_fwft_fifo #(
        .WIDTH(8),
        .DEPTH(32),
        .PROG_FULL(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .wr_en(wr_en),
        .full(full),
        .prog_full(prog_full),
        .rd_en(rd_en),
        .dout(dout),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        din   = d;
        wr_en = 1'b1;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || prog_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_async flags e/f/p got %b%b%b want 100",
                     empty, full, prog_full);
        end
        cycle();
        rst = 1'b0;
        pop();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || prog_full !== 1'b0) begin
            errors++;
            $display("FAIL rd_empty flags e/f/p got %b%b%b want 100",
                     empty, full, prog_full);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
            checks++;
            if (prog_full !== (i + 1 >= 6) || full !== (i == 31) ||
                empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d e/f/p got %b%b%b", i,
                         empty, full, prog_full);
            end
        end
        push(8'hAA);
        checks++;
        if (full !== 1'b1 || dout !== 8'h00) begin
            errors++;
            $display("FAIL wr_full full=%b dout=%h want 1 00", full, dout);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dout !== 8'(i) || empty !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d dout=%h empty=%b want %h 0",
                         i, dout, empty, 8'(i));
            end
            pop();
            checks++;
            if (empty !== (i == 31) || prog_full !== (31 - i >= 6) ||
                full !== 1'b0) begin
                errors++;
                $display("FAIL drain_flags_%0d e/f/p got %b%b%b", i,
                         empty, full, prog_full);
            end
        end
    endtask

    task automatic test_fwft();
        push(8'h5C);
        checks++;
        if (empty !== 1'b0 || dout !== 8'h5C) begin
            errors++;
            $display("FAIL fwft empty=%b dout=%h want 0 5c", empty, dout);
        end
        pop();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop empty=%b want 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        push(8'h11);
        checks++;
        if (dout !== 8'h11 || empty !== 1'b0) begin
            errors++;
            $display("FAIL sim1_head dout=%h want 11", dout);
        end
        din   = 8'h22;
        wr_en = 1'b1;
        rd_en = 1'b1;
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h22 || empty !== 1'b0) begin
            errors++;
            $display("FAIL sim1_swap dout=%h empty=%b want 22 0",
                     dout, empty);
        end
        pop();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL sim1_count empty=%b want 1", empty);
        end
        for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL simf_fill full=%b want 1", full);
        end
        din   = 8'hEE;
        wr_en = 1'b1;
        rd_en = 1'b1;
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (full !== 1'b0 || dout !== 8'h41) begin
            errors++;
            $display("FAIL simf_pop full=%b dout=%h want 0 41", full, dout);
        end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (dout !== 8'(8'h40 + i) || empty !== 1'b0) begin
                errors++;
                $display("FAIL simf_drain_%0d dout=%h want %h", i, dout,
                         8'(8'h40 + i));
            end
            pop();
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL simf_empty empty=%b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic       w;
        logic       r;
        logic       wa;
        logic       ra;
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (empty !== (q.size() == 0) || full !== (q.size() == 32) ||
                (q.size() > 0 && dout !== q[0])) begin
                errors++;
                $display("FAIL wrap_%0d e=%b f=%b dout=%h size=%0d", c,
                         empty, full, dout, q.size());
            end
            w     = 1'($urandom_range(0, 1));
            r     = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
            wr_en = w;
            rd_en = r;
            wa    = w && (q.size() < 32);
            ra    = r && (q.size() > 0);
            cycle();
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(din);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        while (q.size() > 0) begin
            checks++;
            if (dout !== q[0] || empty !== 1'b0) begin
                errors++;
                $display("FAIL wrap_drain dout=%h want %h", dout, q[0]);
            end
            pop();
            void'(q.pop_front());
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty empty=%b want 1", empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
        checks++;
        if (prog_full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill prog_full=%b empty=%b want 1 0",
                     prog_full, empty);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || prog_full !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst e/f/p got %b%b%b want 100",
                     empty, full, prog_full);
        end
        cycle();
        rst = 1'b0;
        push(8'h01);
        push(8'h02);
        checks++;
        if (dout !== 8'h01 || empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_rd1 dout=%h want 01", dout);
        end
        pop();
        checks++;
        if (dout !== 8'h02 || empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_rd2 dout=%h want 02", dout);
        end
        pop();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_empty empty=%b want 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_fwft();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
